// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM state and transaction owner encodings.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    function automatic owner_t other_side(input owner_t o);
        return (o == OWN_D) ? OWN_I : OWN_D;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between I and D requesters.
// MEM_ARB_RR_EN: ties go to the favoured side instead of always to D.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_ireq,
    input  logic   i_dreq,
`ifdef MEM_ARB_RR_EN
    input  owner_t i_favour,
`endif
    output owner_t o_winner
);

    always_comb begin
        o_winner = OWN_D;
        if (i_ireq && !i_dreq) begin
            o_winner = OWN_I;
        end
`ifdef MEM_ARB_RR_EN
        if (i_ireq && i_dreq) begin
            o_winner = i_favour;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (I-refill / D-access) arbiter onto one memory port, one transaction in flight.
// MEM_ARB_RR_EN: round-robin on simultaneous requests; default is fixed D-over-I priority.
//
//   state | meaning
//   IDLE  | no transaction; pick a winner when any request is seen
//   ISSUE | o_mem_req driven from owner's live inputs until i_mem_ready
//   WAIT  | accepted; waiting for i_mem_rvalid, may re-arbitrate on that cycle
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_imem_req,
    input  logic [ADDR_W-1:0]   i_imem_addr,
    output logic                o_imem_gnt,
    output logic                o_imem_rvalid,
    output logic [DATA_W-1:0]   o_imem_rdata,
    input  logic                i_dmem_req,
    input  logic                i_dmem_we,
    input  logic [ADDR_W-1:0]   i_dmem_addr,
    input  logic [DATA_W-1:0]   i_dmem_wdata,
    input  logic [DATA_W/8-1:0] i_dmem_wstrb,
    output logic                o_dmem_gnt,
    output logic                o_dmem_rvalid,
    output logic [DATA_W-1:0]   o_dmem_rdata,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wstrb,
    input  logic                i_mem_ready,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_ibusy,
    output logic                o_proto_err
);

    state_t r_state;
    state_t w_state_nxt;
    owner_t r_owner;
    owner_t w_owner_nxt;
    owner_t w_winner;
    logic   r_proto_err;
    logic   w_any_req;
    logic   w_mem_req;
    logic   w_gnt;
    logic   w_rsp;
    logic   w_own_d;

    assign w_any_req = i_imem_req || i_dmem_req;
    assign w_own_d   = (r_owner == OWN_D);

`ifdef MEM_ARB_RR_EN
    owner_t r_favour;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_favour <= OWN_D;
        end else if (w_gnt) begin
            r_favour <= other_side(r_owner);
        end
    end

    mem_arb_pick u_pick (
        .i_ireq   (i_imem_req),
        .i_dreq   (i_dmem_req),
        .i_favour (r_favour),
        .o_winner (w_winner)
    );
`else
    mem_arb_pick u_pick (
        .i_ireq   (i_imem_req),
        .i_dreq   (i_dmem_req),
        .o_winner (w_winner)
    );
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_owner     <= OWN_D;
            r_proto_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            if (i_mem_rvalid && (r_state != WAIT)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_mem_req   = 1'b0;
        w_gnt       = 1'b0;
        w_rsp       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ISSUE;
                    w_owner_nxt = w_winner;
                end
            end
            ISSUE: begin
                w_mem_req = 1'b1;
                if (i_mem_ready) begin
                    w_gnt       = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (i_mem_rvalid) begin
                    w_rsp = 1'b1;
                    // Re-arbitrate on the response cycle so back-to-back requests lose no cycle.
                    if (w_any_req) begin
                        w_state_nxt = ISSUE;
                        w_owner_nxt = w_winner;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are masked during the reset cycle itself, whatever state was left behind.
    assign o_mem_req     = w_mem_req && !i_rst;
    assign o_imem_gnt    = w_gnt && !i_rst && !w_own_d;
    assign o_dmem_gnt    = w_gnt && !i_rst && w_own_d;
    assign o_imem_rvalid = w_rsp && !i_rst && !w_own_d;
    assign o_dmem_rvalid = w_rsp && !i_rst && w_own_d;
    assign o_imem_rdata  = o_imem_rvalid ? i_mem_rdata : '0;
    assign o_dmem_rdata  = o_dmem_rvalid ? i_mem_rdata : '0;

    assign o_mem_addr  = w_own_d ? i_dmem_addr : i_imem_addr;
    assign o_mem_we    = w_own_d && i_dmem_we;
    assign o_mem_wdata = w_own_d ? i_dmem_wdata : '0;
    assign o_mem_wstrb = w_own_d ? i_dmem_wstrb : '0;

    assign o_ibusy     = i_imem_req && !o_imem_gnt;
    assign o_proto_err = r_proto_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change just after negedge, outputs checked 1ns later.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_imem_req;
    logic [ADDR_W-1:0]   i_imem_addr;
    logic                o_imem_gnt;
    logic                o_imem_rvalid;
    logic [DATA_W-1:0]   o_imem_rdata;
    logic                i_dmem_req;
    logic                i_dmem_we;
    logic [ADDR_W-1:0]   i_dmem_addr;
    logic [DATA_W-1:0]   i_dmem_wdata;
    logic [DATA_W/8-1:0] i_dmem_wstrb;
    logic                o_dmem_gnt;
    logic                o_dmem_rvalid;
    logic [DATA_W-1:0]   o_dmem_rdata;
    logic                o_mem_req;
    logic                o_mem_we;
    logic [ADDR_W-1:0]   o_mem_addr;
    logic [DATA_W-1:0]   o_mem_wdata;
    logic [DATA_W/8-1:0] o_mem_wstrb;
    logic                i_mem_ready;
    logic                i_mem_rvalid;
    logic [DATA_W-1:0]   i_mem_rdata;
    logic                o_ibusy;
    logic                o_proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_imem_req    (i_imem_req),
        .i_imem_addr   (i_imem_addr),
        .o_imem_gnt    (o_imem_gnt),
        .o_imem_rvalid (o_imem_rvalid),
        .o_imem_rdata  (o_imem_rdata),
        .i_dmem_req    (i_dmem_req),
        .i_dmem_we     (i_dmem_we),
        .i_dmem_addr   (i_dmem_addr),
        .i_dmem_wdata  (i_dmem_wdata),
        .i_dmem_wstrb  (i_dmem_wstrb),
        .o_dmem_gnt    (o_dmem_gnt),
        .o_dmem_rvalid (o_dmem_rvalid),
        .o_dmem_rdata  (o_dmem_rdata),
        .o_mem_req     (o_mem_req),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .o_mem_wstrb   (o_mem_wstrb),
        .i_mem_ready   (i_mem_ready),
        .i_mem_rvalid  (i_mem_rvalid),
        .i_mem_rdata   (i_mem_rdata),
        .o_ibusy       (o_ibusy),
        .o_proto_err   (o_proto_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic nxt();
        @(negedge i_clk);
    endtask

    task automatic silent_d(input string tag);
        chk({tag, "_dgnt"}, 64'(o_dmem_gnt), 64'd0);
        chk({tag, "_drv"}, 64'(o_dmem_rvalid), 64'd0);
        chk({tag, "_drd"}, 64'(o_dmem_rdata), 64'd0);
    endtask

    task automatic do_rst();
        nxt(); i_rst = 1'b1;
        nxt(); i_rst = 1'b0;
    endtask

    logic exp_d;

    initial begin
        i_rst = 1'b1; i_imem_req = 1'b0; i_imem_addr = '0;
        i_dmem_req = 1'b0; i_dmem_we = 1'b0; i_dmem_addr = '0; i_dmem_wdata = '0; i_dmem_wstrb = '0;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;

        // Reset behaviour
        nxt(); #1;
        chk("rst_mreq", 64'(o_mem_req), 64'd0);
        chk("rst_ignt", 64'(o_imem_gnt), 64'd0);
        nxt(); #1;
        chk("rst_perr", 64'(o_proto_err), 64'd0);
        nxt(); i_rst = 1'b0; #1;
        chk("rst_after_mreq", 64'(o_mem_req), 64'd0);
        chk("rst_after_dgnt", 64'(o_dmem_gnt), 64'd0);

        // Single I read, ready on 2nd ISSUE cycle, rvalid 3 cycles after gnt
        nxt(); i_imem_req = 1'b1; i_imem_addr = 32'h100; #1;
        chk("t1_idle_mreq", 64'(o_mem_req), 64'd0);
        chk("t1_idle_ibusy", 64'(o_ibusy), 64'd1);
        nxt(); #1;
        chk("t1_iss_mreq", 64'(o_mem_req), 64'd1);
        chk("t1_iss_addr", 64'(o_mem_addr), 64'h100);
        chk("t1_iss_we", 64'(o_mem_we), 64'd0);
        chk("t1_iss_ignt0", 64'(o_imem_gnt), 64'd0);
        nxt(); i_mem_ready = 1'b1; #1;
        chk("t1_ignt", 64'(o_imem_gnt), 64'd1);
        chk("t1_ibusy_gnt", 64'(o_ibusy), 64'd0);
        silent_d("t1_gnt");
        nxt(); i_mem_ready = 1'b0; i_imem_req = 1'b0; #1;
        chk("t1_wait_mreq", 64'(o_mem_req), 64'd0);
        chk("t1_wait_irv", 64'(o_imem_rvalid), 64'd0);
        nxt(); #1;
        chk("t1_wait2_ignt", 64'(o_imem_gnt), 64'd0);
        nxt(); i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEADBEEF; #1;
        chk("t1_irv", 64'(o_imem_rvalid), 64'd1);
        chk("t1_ird", 64'(o_imem_rdata), 64'hDEADBEEF);
        silent_d("t1_rsp");
        nxt(); i_mem_rvalid = 1'b0; i_mem_rdata = '0; #1;
        chk("t1_done_irv", 64'(o_imem_rvalid), 64'd0);
        chk("t1_done_perr", 64'(o_proto_err), 64'd0);

        // Simultaneous: D write first, then I read back-to-back
        nxt();
        i_imem_req = 1'b1; i_imem_addr = 32'h200;
        i_dmem_req = 1'b1; i_dmem_we = 1'b1; i_dmem_addr = 32'h300;
        i_dmem_wdata = 32'h12345678; i_dmem_wstrb = 4'hF; #1;
        chk("t2_idle_ibusy", 64'(o_ibusy), 64'd1);
        nxt(); i_mem_ready = 1'b1; #1;
        chk("t2_d_addr", 64'(o_mem_addr), 64'h300);
        chk("t2_d_we", 64'(o_mem_we), 64'd1);
        chk("t2_d_wdata", 64'(o_mem_wdata), 64'h12345678);
        chk("t2_d_wstrb", 64'(o_mem_wstrb), 64'hF);
        chk("t2_dgnt", 64'(o_dmem_gnt), 64'd1);
        chk("t2_ignt0", 64'(o_imem_gnt), 64'd0);
        chk("t2_ibusy_d", 64'(o_ibusy), 64'd1);
        nxt(); i_mem_ready = 1'b0; i_dmem_req = 1'b0; i_dmem_we = 1'b0;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0; #1;
        chk("t2_dack", 64'(o_dmem_rvalid), 64'd1);
        chk("t2_irv0", 64'(o_imem_rvalid), 64'd0);
        chk("t2_ibusy_w", 64'(o_ibusy), 64'd1);
        nxt(); i_mem_rvalid = 1'b0; i_mem_ready = 1'b1; #1;
        chk("t2_i_mreq", 64'(o_mem_req), 64'd1);
        chk("t2_i_addr", 64'(o_mem_addr), 64'h200);
        chk("t2_i_we", 64'(o_mem_we), 64'd0);
        chk("t2_i_wstrb", 64'(o_mem_wstrb), 64'h0);
        chk("t2_ignt", 64'(o_imem_gnt), 64'd1);
        chk("t2_ibusy_clr", 64'(o_ibusy), 64'd0);
        nxt(); i_mem_ready = 1'b0; i_imem_req = 1'b0;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFEF00D; #1;
        chk("t2_irv", 64'(o_imem_rvalid), 64'd1);
        chk("t2_ird", 64'(o_imem_rdata), 64'hCAFEF00D);
        nxt(); i_mem_rvalid = 1'b0; i_mem_rdata = '0; #1;
        chk("t2_idle_mreq", 64'(o_mem_req), 64'd0);

        // D request arriving during I WAIT issues on the rvalid cycle; then ready stalls 10 cycles
        nxt(); i_imem_req = 1'b1; i_imem_addr = 32'h400;
        nxt(); i_mem_ready = 1'b1; #1;
        chk("t3_ignt", 64'(o_imem_gnt), 64'd1);
        nxt(); i_mem_ready = 1'b0; i_imem_req = 1'b0;
        i_dmem_req = 1'b1; i_dmem_addr = 32'h500; i_dmem_wstrb = '0; #1;
        chk("t3_wait_mreq", 64'(o_mem_req), 64'd0);
        chk("t3_wait_dgnt", 64'(o_dmem_gnt), 64'd0);
        nxt(); i_mem_rvalid = 1'b1; i_mem_rdata = 32'h11112222; #1;
        chk("t3_irv", 64'(o_imem_rvalid), 64'd1);
        chk("t3_drv0", 64'(o_dmem_rvalid), 64'd0);
        for (int k = 0; k < 10; k++) begin
            nxt(); i_mem_rvalid = 1'b0; i_mem_rdata = '0; #1;
            chk("t3_stall_mreq", 64'(o_mem_req), 64'd1);
            chk("t3_stall_addr", 64'(o_mem_addr), 64'h500);
            chk("t3_stall_dgnt", 64'(o_dmem_gnt), 64'd0);
        end
        nxt(); i_mem_ready = 1'b1; #1;
        chk("t3_dgnt", 64'(o_dmem_gnt), 64'd1);
        chk("t3_d_we", 64'(o_mem_we), 64'd0);
        nxt(); i_mem_ready = 1'b0; i_dmem_req = 1'b0;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h33334444; #1;
        chk("t3_drv", 64'(o_dmem_rvalid), 64'd1);
        chk("t3_drd", 64'(o_dmem_rdata), 64'h33334444);
        chk("t3_ird0", 64'(o_imem_rdata), 64'h0);
        nxt(); i_mem_rvalid = 1'b0; i_mem_rdata = '0;

        // Both held for 4 transactions from a fresh reset
        do_rst();
        nxt(); i_imem_req = 1'b1; i_imem_addr = 32'h700;
        i_dmem_req = 1'b1; i_dmem_addr = 32'h780; #1;
        chk("t4_idle_ibusy", 64'(o_ibusy), 64'd1);
        for (int k = 0; k < 4; k++) begin
            exp_d = 1'b1;
`ifdef MEM_ARB_RR_EN
            exp_d = (k % 2 == 0);
`endif
            nxt(); i_mem_ready = 1'b1; i_mem_rvalid = 1'b0; #1;
            chk("t4_dgnt", 64'(o_dmem_gnt), 64'(exp_d));
            chk("t4_ignt", 64'(o_imem_gnt), 64'(!exp_d));
            chk("t4_addr", 64'(o_mem_addr), exp_d ? 64'h780 : 64'h700);
            nxt(); i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'(k + 1);
            if (k == 3) begin
                i_imem_req = 1'b0; i_dmem_req = 1'b0;
            end
            #1;
            chk("t4_rv", 64'(exp_d ? o_dmem_rvalid : o_imem_rvalid), 64'd1);
            chk("t4_rd", 64'(exp_d ? o_dmem_rdata : o_imem_rdata), 64'(k + 1));
        end
        nxt(); i_mem_rvalid = 1'b0; i_mem_rdata = '0; #1;
        chk("t4_end_mreq", 64'(o_mem_req), 64'd0);

        // Reset in WAIT, late rvalid 2 cycles later
        nxt(); i_imem_req = 1'b1; i_imem_addr = 32'h600;
        nxt(); i_mem_ready = 1'b1; #1;
        chk("t5_ignt", 64'(o_imem_gnt), 64'd1);
        nxt(); i_mem_ready = 1'b0; i_imem_req = 1'b0; i_rst = 1'b1; #1;
        chk("t5_rst_mreq", 64'(o_mem_req), 64'd0);
        nxt(); i_rst = 1'b0; #1;
        chk("t5_post_mreq", 64'(o_mem_req), 64'd0);
        nxt(); i_mem_rvalid = 1'b1; i_mem_rdata = 32'h55556666; #1;
        chk("t5_irv0", 64'(o_imem_rvalid), 64'd0);
        chk("t5_ird0", 64'(o_imem_rdata), 64'd0);
        chk("t5_drv0", 64'(o_dmem_rvalid), 64'd0);
        nxt(); i_mem_rvalid = 1'b0; i_mem_rdata = '0; #1;
        chk("t5_perr", 64'(o_proto_err), 64'd1);
        nxt(); #1;
        chk("t5_perr_sticky", 64'(o_proto_err), 64'd1);

        // Reset landing in ISSUE with ready high must suppress req and gnt
        nxt(); i_imem_req = 1'b1; i_imem_addr = 32'h680;
        nxt(); i_mem_ready = 1'b1; i_rst = 1'b1; #1;
        chk("t6_rst_mreq", 64'(o_mem_req), 64'd0);
        chk("t6_rst_ignt", 64'(o_imem_gnt), 64'd0);
        nxt(); i_rst = 1'b0; i_mem_ready = 1'b0; i_imem_req = 1'b0; #1;
        chk("t6_post_mreq", 64'(o_mem_req), 64'd0);
        chk("t6_perr_clr", 64'(o_proto_err), 64'd0);

        nxt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
